// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the write-back queue.
//   REG_ZERO   : architectural zero register, writes to it are dropped
//   WB_DW/WB_AW: default data / register-address widths
//   wb_entry_t : one queued register-file write {addr, data}
package wb_pkg;

   localparam int unsigned WB_DW = 32;
   localparam int unsigned WB_AW = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// wb_lookup: youngest-match search over the write-back queue storage.
//   i_addr/i_data : physical entry array
//   i_valid       : per-slot occupancy mask
//   i_head        : slot index of the oldest entry
//   i_qaddr       : register being looked up
//   o_hit_c       : some queued entry targets i_qaddr (never for $0)
//   o_data_c      : data of the youngest such entry, 0 when no hit
module wb_lookup
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = WB_DW,
   parameter int unsigned AW    = WB_AW
) (
   input  logic [AW-1:0]            i_addr [DEPTH],
   input  logic [DW-1:0]            i_data [DEPTH],
   input  logic [DEPTH-1:0]         i_valid,
   input  logic [$clog2(DEPTH)-1:0] i_head,
   input  logic [AW-1:0]            i_qaddr,
   output logic                     o_hit_c,
   output logic [DW-1:0]            o_data_c
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      o_hit_c  = 1'b0;
      o_data_c = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         if (i_valid[i_head + PW'(k)] &&
             (i_addr[i_head + PW'(k)] == i_qaddr) &&
             (i_qaddr != ADDR_ZERO)) begin
            o_hit_c  = 1'b1;
            o_data_c = i_data[i_head + PW'(k)];
         end
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: merges ALU (port 0) and load (port 1) results into the
// single register-file write port through an in-order FIFO.
//   clk, rst            : clock, asynchronous active-high reset
//   in0_*/in1_*         : valid/addr/data producers with ready backpressure
//   rf_we/waddr/wdata   : register-file write port, head of the queue
//   qa_*/qb_*           : pending-write lookups (active with WB_BYPASS_EN)
//   empty               : nothing queued
// Build option: define WB_BYPASS_EN to synthesise the pending-write lookup;
// otherwise the lookup outputs are tied to zero.
module wb_write_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = WB_DW,
   parameter int unsigned AW    = WB_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in0_valid,
   input  logic [AW-1:0] in0_addr,
   input  logic [DW-1:0] in0_data,
   output logic          in0_ready,
   input  logic          in1_valid,
   input  logic [AW-1:0] in1_addr,
   input  logic [DW-1:0] in1_data,
   output logic          in1_ready,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   input  logic [AW-1:0] qa_addr,
   input  logic [AW-1:0] qb_addr,
   output logic          qa_hit,
   output logic          qb_hit,
   output logic [DW-1:0] qa_data,
   output logic [DW-1:0] qb_data,
   output logic          empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] LVL_ONE_FREE = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LVL_TWO_FREE = CW'(DEPTH - 2);
   localparam logic [AW-1:0] ADDR_ZERO    = AW'(REG_ZERO);

   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_in0_ready;
   logic          w_in1_ready;
   logic          w_push0;
   logic          w_push1;
   logic          w_pop;
   logic [PW-1:0] w_slot1;

   // Readiness looks only at the registered count; this cycle's pop is ignored.
   assign w_in0_ready = (r_count <= LVL_ONE_FREE);
   assign w_in1_ready = (in0_valid && w_in0_ready) ? (r_count <= LVL_TWO_FREE)
                                                   : (r_count <= LVL_ONE_FREE);

   // $0 writes complete the handshake but never occupy a slot.
   assign w_push0 = in0_valid && w_in0_ready && (in0_addr != ADDR_ZERO);
   assign w_push1 = in1_valid && w_in1_ready && (in1_addr != ADDR_ZERO);
   assign w_pop   = (r_count != '0);

   // Port 1 lands behind port 0 when both store in the same cycle.
   assign w_slot1 = w_push0 ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

   // Pointer and occupancy state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(w_push0) + PW'(w_push1);
         r_rd_ptr <= r_rd_ptr + PW'(w_pop);
         r_count  <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
      end
   end

   // Entry storage, deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (w_push0) begin
         r_addr[r_wr_ptr] <= in0_addr;
         r_data[r_wr_ptr] <= in0_data;
      end
      if (w_push1) begin
         r_addr[w_slot1] <= in1_addr;
         r_data[w_slot1] <= in1_data;
      end
   end

   assign in0_ready = w_in0_ready;
   assign in1_ready = w_in1_ready;
   assign rf_we     = w_pop;
   assign rf_waddr  = r_addr[r_rd_ptr];
   assign rf_wdata  = r_data[r_rd_ptr];
   assign empty     = !w_pop;

`ifdef WB_BYPASS_EN
   logic [DEPTH-1:0] w_valid;

   // A slot is live when its distance from the head is below the count.
   always_comb begin
      w_valid = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_valid[i] = ({1'b0, PW'(PW'(i) - r_rd_ptr)} < r_count);
      end
   end

   wb_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lookup_a (
      .i_addr   (r_addr),
      .i_data   (r_data),
      .i_valid  (w_valid),
      .i_head   (r_rd_ptr),
      .i_qaddr  (qa_addr),
      .o_hit_c  (qa_hit),
      .o_data_c (qa_data)
   );

   wb_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lookup_b (
      .i_addr   (r_addr),
      .i_data   (r_data),
      .i_valid  (w_valid),
      .i_head   (r_rd_ptr),
      .i_qaddr  (qb_addr),
      .o_hit_c  (qb_hit),
      .o_data_c (qb_data)
   );
`else
   logic w_unused;

   assign w_unused = ^{qa_addr, qb_addr};
   assign qa_hit   = 1'b0;
   assign qb_hit   = 1'b0;
   assign qa_data  = '0;
   assign qb_data  = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed stimulus against a queue-based reference of the
// write-back queue, plus literal expectations for the headline scenarios.
module tb_wb_write_queue;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in0_valid = 1'b0;
   logic [4:0]  in0_addr  = '0;
   logic [31:0] in0_data  = '0;
   logic        in0_ready;
   logic        in1_valid = 1'b0;
   logic [4:0]  in1_addr  = '0;
   logic [31:0] in1_data  = '0;
   logic        in1_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  qa_addr = '0;
   logic [4:0]  qb_addr = '0;
   logic        qa_hit;
   logic        qb_hit;
   logic [31:0] qa_data;
   logic [31:0] qb_data;
   logic        empty;

   int n_checks = 0;
   int n_errors = 0;

   ent_t mq[$];

   always #5 clk = ~clk;

   wb_write_queue #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_addr  (in0_addr),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_addr  (in1_addr),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .qa_addr   (qa_addr),
      .qb_addr   (qb_addr),
      .qa_hit    (qa_hit),
      .qb_hit    (qb_hit),
      .qa_data   (qa_data),
      .qb_data   (qb_data),
      .empty     (empty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest queued write to register a; $0 never matches.
   function automatic void model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
`ifdef WB_BYPASS_EN
      foreach (mq[i]) begin
         if (a != 5'd0 && mq[i].a == a) begin
            h = 1'b1;
            d = mq[i].d;
         end
      end
`endif
   endfunction

   // Reference queue: accept by free slots, retire the head each cycle, drop $0.
   int  m_sz;
   bit  m_a0, m_a1;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
      end else begin
         m_sz = mq.size();
         m_a0 = in0_valid && (m_sz < DEPTH);
         m_a1 = in1_valid && (m_a0 ? (m_sz + 2 <= DEPTH) : (m_sz < DEPTH));
         if (m_sz > 0) void'(mq.pop_front());
         if (m_a0 && in0_addr != 5'd0) mq.push_back('{a: in0_addr, d: in0_data});
         if (m_a1 && in1_addr != 5'd0) mq.push_back('{a: in1_addr, d: in1_data});
      end
   end

   // Every-cycle comparison against the reference queue.
   int          c_sz;
   bit          c_r0, c_r1;
   logic        c_h;
   logic [31:0] c_d;
   always @(negedge clk) begin
      c_sz = mq.size();
      c_r0 = (c_sz < DEPTH);
      c_r1 = (in0_valid && c_r0) ? (c_sz + 2 <= DEPTH) : (c_sz < DEPTH);
      chk("m_rf_we", 32'(rf_we), 32'(c_sz != 0));
      chk("m_empty", 32'(empty), 32'(c_sz == 0));
      if (c_sz != 0) begin
         chk("m_rf_waddr", 32'(rf_waddr), 32'(mq[0].a));
         chk("m_rf_wdata", rf_wdata, mq[0].d);
      end
      chk("m_in0_ready", 32'(in0_ready), 32'(c_r0));
      chk("m_in1_ready", 32'(in1_ready), 32'(c_r1));
      model_lookup(qa_addr, c_h, c_d);
      chk("m_qa_hit", 32'(qa_hit), 32'(c_h));
      chk("m_qa_data", qa_data, c_d);
      model_lookup(qb_addr, c_h, c_d);
      chk("m_qb_hit", 32'(qb_hit), 32'(c_h));
      chk("m_qb_data", qb_data, c_d);
   end

   task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      @(posedge clk);
      #1;
      in0_valid = v0; in0_addr = a0; in0_data = d0;
      in1_valid = v1; in1_addr = a1; in1_data = d1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic single_write(input string tag);
      drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk({tag, "_in0_ready"}, 32'(in0_ready), 32'd1);
      idle();
      @(negedge clk);
      chk({tag, "_rf_we"}, 32'(rf_we), 32'd1);
      chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd8);
      chk({tag, "_rf_wdata"}, rf_wdata, 32'hDEADBEEF);
      @(negedge clk);
      chk({tag, "_rf_we_after"}, 32'(rf_we), 32'd0);
      chk({tag, "_empty_after"}, 32'(empty), 32'd1);
   endtask

   int acc_exp[4] = '{2, 2, 1, 1};
   int in1r_exp[4] = '{1, 1, 0, 0};

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_qa_hit", 32'(qa_hit), 32'd0);

      single_write("single");

      // Same register from both ports: port 0 retires first.
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
      idle();
      @(negedge clk);
      chk("dual_first_addr", 32'(rf_waddr), 32'd3);
      chk("dual_first_data", rf_wdata, 32'h11);
      @(negedge clk);
      chk("dual_second_addr", 32'(rf_waddr), 32'd3);
      chk("dual_second_data", rf_wdata, 32'h22);
      @(negedge clk);
      chk("dual_empty", 32'(empty), 32'd1);

      // Both ports hammering: occupancy climbs 0,2,3,3.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 5'(10 + k), 32'(100 + k), 1'b1, 5'(20 + k), 32'(200 + k));
         @(negedge clk);
         chk("burst_accepted", 32'(int'(in0_valid && in0_ready) + int'(in1_valid && in1_ready)),
             32'(acc_exp[k]));
         chk("burst_in1_ready", 32'(in1_ready), 32'(in1r_exp[k]));
      end
      idle();
      repeat (5) @(negedge clk);
      chk("burst_drained", 32'(empty), 32'd1);

      // $0 write: handshake completes, nothing reaches the register file.
      drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("zero_in0_ready", 32'(in0_ready), 32'd1);
      idle();
      @(negedge clk);
      chk("zero_rf_we", 32'(rf_we), 32'd0);
      chk("zero_empty", 32'(empty), 32'd1);

      // Lookup returns the youngest pending value.
      qa_addr = 5'd9;
      qb_addr = 5'd0;
      drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
      idle();
      @(negedge clk);
`ifdef WB_BYPASS_EN
      chk("byp_two_hit", 32'(qa_hit), 32'd1);
      chk("byp_two_data", qa_data, 32'hB);
`else
      chk("byp_two_hit", 32'(qa_hit), 32'd0);
      chk("byp_two_data", qa_data, 32'h0);
`endif
      chk("byp_two_qb_hit", 32'(qb_hit), 32'd0);
      @(negedge clk);
`ifdef WB_BYPASS_EN
      chk("byp_one_hit", 32'(qa_hit), 32'd1);
      chk("byp_one_data", qa_data, 32'hB);
`else
      chk("byp_one_hit", 32'(qa_hit), 32'd0);
`endif
      @(negedge clk);
      chk("byp_drained_hit", 32'(qa_hit), 32'd0);

      // Asynchronous reset with three writes pending.
      qa_addr = 5'd6;
      drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd5, 32'h50);
      drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h70);
      idle();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_rf_we", 32'(rf_we), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_qa_hit", 32'(qa_hit), 32'd0);
      chk("midrst_qb_hit", 32'(qb_hit), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_still_empty", 32'(empty), 32'd1);

      single_write("post_rst");

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
